// File: rtl/subsoc_wb_arb2.sv
// Two-initiator, one-target WISHBONE classic arbiter. Round-robin grant held for a
// whole cycle; a bus-timeout watchdog returns err to the owner of a hung transfer.
module subsoc_wb_arb2 #(
  parameter int WB_AW  = 16,
  parameter int WB_DW  = 32,
  parameter int TO_W   = 8,
  parameter int TO_CYC = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [WB_AW-3:0]     m0_adr_i,
  input  logic [WB_DW/8-1:0]   m0_sel_i,
  input  logic [WB_DW-1:0]     m0_dat_i,
  output logic [WB_DW-1:0]     m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [WB_AW-3:0]     m1_adr_i,
  input  logic [WB_DW/8-1:0]   m1_sel_i,
  input  logic [WB_DW-1:0]     m1_dat_i,
  output logic [WB_DW-1:0]     m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [WB_AW-3:0]     s_adr_o,
  output logic [WB_DW/8-1:0]   s_sel_o,
  output logic [WB_DW-1:0]     s_dat_o,
  input  logic [WB_DW-1:0]     s_dat_i,
  input  logic                 s_ack_i,
  output logic [1:0]           gnt_o,
  output logic                 to_evt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS0 = 2'd1,
    BUS1 = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] WD_MAX  = {TO_W{1'b1}};
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_CYC - 1);

  state_t          r_state;
  logic            r_last_gnt;
  logic [TO_W-1:0] r_wd;

  logic w_own0;
  logic w_own1;
  logic w_own_cyc;
  logic w_own_stb;
  logic w_other_cyc;
  logic w_to;

  // Owner-side request view and the watchdog expiry condition (ack beats timeout).
  always_comb begin
    w_own0      = (r_state == BUS0);
    w_own1      = (r_state == BUS1);
    w_own_cyc   = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);
    w_own_stb   = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);
    w_other_cyc = (w_own0 & m1_cyc_i) | (w_own1 & m0_cyc_i);
    w_to        = (TO_CYC != 0) && w_own_stb && !s_ack_i && (r_wd == WD_LAST);
  end

  // Target-side mux and response routing; nothing reaches a master without its grant.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = {w_own1, w_own0};
    to_evt_o = w_to;
    case (r_state)
      BUS0: begin
        s_cyc_o  = m0_cyc_i & ~w_to;
        s_stb_o  = m0_stb_i & ~w_to;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = w_to;
      end
      BUS1: begin
        s_cyc_o  = m1_cyc_i & ~w_to;
        s_stb_o  = m1_stb_i & ~w_to;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = w_to;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

  // Arbitration FSM, round-robin history and saturating watchdog counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_wd       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wd <= '0;
          if (m0_cyc_i && m1_cyc_i) begin
            r_state <= r_last_gnt ? BUS0 : BUS1;
          end else if (m0_cyc_i) begin
            r_state <= BUS0;
          end else if (m1_cyc_i) begin
            r_state <= BUS1;
          end else begin
            r_state <= IDLE;
          end
        end
        BUS0, BUS1: begin
          if (!w_own_cyc || w_to) begin
            r_last_gnt <= w_own1;
            r_wd       <= '0;
            if (w_other_cyc) begin
              r_state <= w_own0 ? BUS1 : BUS0;
            end else begin
              r_state <= IDLE;
            end
          end else if (!w_own_stb || s_ack_i) begin
            r_wd <= '0;
          end else if (r_wd != WD_MAX) begin
            r_wd <= r_wd + {{(TO_W-1){1'b0}}, 1'b1};
          end else begin
            r_wd <= r_wd;
          end
        end
        default: begin
          r_state <= IDLE;
          r_wd    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subsoc_wb_arb2.sv
// Randomized and directed bench for subsoc_wb_arb2 against a transaction-level
// reference model of owner, round-robin history and stalled-strobe count.
module tb_subsoc_wb_arb2;

  localparam int TO_CYC = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  cyc, stb, we;
  logic [13:0] adr [2];
  logic [3:0]  sel [2];
  logic [31:0] wdat [2];
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [13:0] s_adr_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_o;
  logic [1:0]  gnt_o;
  logic        to_evt_o;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int m_owner;
  int m_last;
  int m_stall;

  subsoc_wb_arb2 #(.WB_AW(16), .WB_DW(32), .TO_W(8), .TO_CYC(TO_CYC)) dut (
    .wb_clk_i(clk),      .wb_rst_i(rst),
    .m0_cyc_i(cyc[0]),   .m0_stb_i(stb[0]),  .m0_we_i(we[0]),
    .m0_adr_i(adr[0]),   .m0_sel_i(sel[0]),  .m0_dat_i(wdat[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc[1]),   .m1_stb_i(stb[1]),  .m1_we_i(we[1]),
    .m1_adr_i(adr[1]),   .m1_sel_i(sel[1]),  .m1_dat_i(wdat[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o),   .s_stb_o(s_stb_o),  .s_we_o(s_we_o),
    .s_adr_o(s_adr_o),   .s_sel_o(s_sel_o),  .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i),   .s_ack_i(s_ack_i),
    .gnt_o(gnt_o),       .to_evt_o(to_evt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit model_timeout();
    if (m_owner < 0 || TO_CYC == 0) return 1'b0;
    return stb[m_owner] && !s_ack_i && (m_stall == TO_CYC - 1);
  endfunction

  task automatic check_model();
    bit to;
    int o;
    o  = m_owner;
    to = model_timeout();
    chk("gnt",    gnt_o,   (o < 0) ? 0 : (1 << o));
    chk("s_cyc",  s_cyc_o, (o >= 0) ? (cyc[o] && !to) : 0);
    chk("s_stb",  s_stb_o, (o >= 0) ? (stb[o] && !to) : 0);
    chk("s_we",   s_we_o,  (o >= 0) ? we[o]   : 0);
    chk("s_adr",  s_adr_o, (o >= 0) ? adr[o]  : 0);
    chk("s_sel",  s_sel_o, (o >= 0) ? sel[o]  : 0);
    chk("s_dat",  s_dat_o, (o >= 0) ? wdat[o] : 0);
    chk("m0_ack", m0_ack_o, (o == 0) && s_ack_i);
    chk("m1_ack", m1_ack_o, (o == 1) && s_ack_i);
    chk("m0_err", m0_err_o, (o == 0) && to);
    chk("m1_err", m1_err_o, (o == 1) && to);
    chk("m0_dat", m0_dat_o, (o == 0) ? s_dat_i : 0);
    chk("m1_dat", m1_dat_o, (o == 1) ? s_dat_i : 0);
    chk("to_evt", to_evt_o, to);
  endtask

  task automatic model_clock();
    bit to;
    to = model_timeout();
    if (rst) begin
      m_owner = -1; m_last = 1; m_stall = 0;
    end else if (m_owner < 0) begin
      m_stall = 0;
      if (cyc == 2'b11)  m_owner = 1 - m_last;
      else if (cyc[0])   m_owner = 0;
      else if (cyc[1])   m_owner = 1;
    end else if (!cyc[m_owner] || to) begin
      m_last  = m_owner;
      m_owner = cyc[1 - m_owner] ? 1 - m_owner : -1;
      m_stall = 0;
    end else if (stb[m_owner] && !s_ack_i) begin
      m_stall = (m_stall < 255) ? m_stall + 1 : 255;
    end else begin
      m_stall = 0;
    end
  endtask

  // inputs are set at the falling edge; compare mid-cycle, then advance one clock
  task automatic step();
    #2;
    check_model();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  initial begin
    int ack_pct;
    rst = 1'b1; cyc = 2'b00; stb = 2'b00; we = 2'b00;
    s_ack_i = 1'b0; s_dat_i = 32'h0;
    for (int i = 0; i < 2; i++) begin
      adr[i] = 14'h0; sel[i] = 4'h0; wdat[i] = 32'h0;
    end
    m_owner = -1; m_last = 1; m_stall = 0;
    @(posedge clk);
    @(negedge clk);
    step();

    // single m0 read, ack on second strobe cycle
    rst = 1'b0; cyc = 2'b01; stb = 2'b01; adr[0] = 14'h0010; sel[0] = 4'hF;
    #1 chk("t1_gnt_idle", gnt_o, 2'b00);
    step();
    #1 chk("t1_gnt", gnt_o, 2'b01);
    chk("t1_s_stb", s_stb_o, 1'b1);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hA5A5_0001;
    #1 chk("t1_m0_dat", m0_dat_o, 32'hA5A5_0001);
    chk("t1_m0_ack", m0_ack_o, 1'b1);
    chk("t1_m1_ack", m1_ack_o, 1'b0);
    step();
    s_ack_i = 1'b0; cyc = 2'b00; stb = 2'b00;
    step();

    // simultaneous request after reset, handover without idle gap
    rst = 1'b1;
    step();
    rst = 1'b0; cyc = 2'b11; stb = 2'b11;
    step();
    #1 chk("t2_gnt_m0", gnt_o, 2'b01);
    s_ack_i = 1'b1;
    step();
    s_ack_i = 1'b0; cyc = 2'b10; stb = 2'b10; we[1] = 1'b1;
    wdat[1] = 32'h0000_1234; sel[1] = 4'hF;
    step();
    #1 chk("t2_gnt_m1", gnt_o, 2'b10);
    chk("t2_s_dat", s_dat_o, 32'h0000_1234);
    chk("t2_s_sel", s_sel_o, 4'hF);
    chk("t2_s_we",  s_we_o, 1'b1);
    s_ack_i = 1'b1;
    step();
    s_ack_i = 1'b0; cyc = 2'b00; stb = 2'b00; we = 2'b00;
    step();

    // continuous 1-beat requests from both: grants must alternate
    cyc = 2'b11; stb = 2'b11; s_ack_i = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      #1 chk("t3_alt", gnt_o, (i % 2) ? 2'b10 : 2'b01);
      step();
      cyc[i % 2] = 1'b0;
      step();
      cyc = 2'b11;
    end
    cyc = 2'b00; stb = 2'b00; s_ack_i = 1'b0;
    step();
    step();

    // m1 stalls until timeout while m0 waits
    cyc = 2'b10; stb = 2'b10;
    step();
    cyc = 2'b11; stb = 2'b11;
    for (int i = 0; i < 3; i++) step();
    #1 chk("t4_m1_err", m1_err_o, 1'b1);
    chk("t4_to_evt", to_evt_o, 1'b1);
    chk("t4_s_stb",  s_stb_o, 1'b0);
    chk("t4_m0_err", m0_err_o, 1'b0);
    step();
    #1 chk("t4_gnt_m0", gnt_o, 2'b01);
    step();

    // ack on the would-be timeout cycle wins
    cyc = 2'b10; stb = 2'b10;
    step();
    #1 chk("t5_gnt_m1", gnt_o, 2'b10);
    for (int i = 0; i < 3; i++) step();
    s_ack_i = 1'b1; s_dat_i = 32'h5A5A_0004;
    #1 chk("t5_m1_ack", m1_ack_o, 1'b1);
    chk("t5_m1_err", m1_err_o, 1'b0);
    chk("t5_to_evt", to_evt_o, 1'b0);
    step();
    s_ack_i = 1'b0;
    #1 chk("t5_no_err", m1_err_o, 1'b0);
    step();

    // reset mid-transfer with m1 owning
    rst = 1'b1;
    step();
    rst = 1'b0; cyc = 2'b11; stb = 2'b11;
    #1 chk("t6_gnt", gnt_o, 2'b00);
    chk("t6_s_cyc", s_cyc_o, 1'b0);
    chk("t6_s_dat", s_dat_o, 32'h0);
    step();
    #1 chk("t6_tie_m0", gnt_o, 2'b01);
    cyc = 2'b00; stb = 2'b00;
    step();
    step();

    // randomized traffic with phases of responsive and hung slave
    ack_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) ack_pct = ($urandom_range(0, 1) == 0) ? 5 : 50;
      rst = ($urandom_range(0, 199) == 0);
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 7) == 0) cyc[m] = ~cyc[m];
        stb[m]  = cyc[m] & ($urandom_range(0, 3) != 0);
        we[m]   = $urandom_range(0, 1);
        adr[m]  = 14'($urandom);
        sel[m]  = 4'($urandom);
        wdat[m] = $urandom;
      end
      s_ack_i = ($urandom_range(0, 99) < ack_pct);
      s_dat_i = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
